// File: rtl/float_pkg.sv
// Single-precision float field definitions shared by the float datapath blocks.
package float_pkg;

  localparam int FLT_BIAS  = 127;
  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;

  typedef struct packed {
    logic                 sign;
    logic [FLT_EXP_W-1:0] exp;
    logic [FLT_MAN_W-1:0] man;
  } float_t;

endpackage

// File: rtl/float_to_int_nb.sv
// Pipelined single-precision float to signed WIDTH-bit integer converter.
// Rounds half away from zero, saturates, 3-cycle latency, no back-pressure.
module float_to_int_nb
  import float_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_sat
);

  localparam logic signed [8:0] BIAS_S   = 9'(FLT_BIAS);
  localparam logic signed [8:0] WIDTH_S  = 9'(WIDTH);
  localparam logic [WIDTH:0]    POS_MAX  = (WIDTH+1)'((64'd1 << (WIDTH-1)) - 64'd1);
  localparam logic [WIDTH:0]    NEG_MAX  = (WIDTH+1)'(64'd1 << (WIDTH-1));
  localparam logic [WIDTH-1:0]  OUT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  OUT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  // stage-valid pipeline
  logic v1, v2;

  // stage 1 state
  logic                s1_sign;
  logic [23:0]         s1_mant;
  logic signed [8:0]   s1_e;
  logic                s1_zero, s1_ovf, s1_spec;

  // stage 2 state
  logic                s2_sign;
  logic [WIDTH:0]      s2_mag;
  logic                s2_spec;

  // combinational nets
  float_t              f;
  logic signed [8:0]   e_c;
  logic                zero_c, ovf_c, spec_c;
  logic [5:0]          sh;
  logic [WIDTH+1:0]    q;
  logic [WIDTH:0]      mag_c;
  logic                over_c;
  logic [WIDTH-1:0]    res_c;

  // unpack and classify the incoming operand
  always_comb begin
    f      = din;
    e_c    = $signed({1'b0, f.exp}) - BIAS_S;
    spec_c = &f.exp;
    zero_c = (f.exp == '0) || (e_c < -9'sd1);
    ovf_c  = spec_c || (e_c >= WIDTH_S);
  end

  // valid flops need async reset, so they are kept apart from the data path
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      v1         <= din_valid;
      v2         <= v1;
      dout_valid <= v2;
    end
  end

  // stage 1 registers, loaded only for valid input
  always_ff @(posedge clk) begin
    if (din_valid) begin
      s1_sign <= f.sign;
      s1_mant <= {1'b1, f.man};
      s1_e    <= e_c;
      s1_zero <= zero_c;
      s1_ovf  <= ovf_c;
      s1_spec <= spec_c;
    end
  end

  // magnitude: q = floor(mant24 * 2^(e-22)) holds the integer part and the
  // 0.5 bit together, so adding q[0] to q>>1 rounds half away from zero
  always_comb begin
    sh = 6'(WIDTH + 22 - int'(s1_e));
    q  = (WIDTH+2)'({s1_mant, {WIDTH{1'b0}}} >> sh);
    if (s1_zero)
      mag_c = '0;
    else if (s1_ovf)
      mag_c = '1;
    else
      mag_c = q[WIDTH+1:1] + (WIDTH+1)'(q[0]);
  end

  // stage 2 registers
  always_ff @(posedge clk) begin
    if (v1) begin
      s2_sign <= s1_sign;
      s2_mag  <= mag_c;
      s2_spec <= s1_spec;
    end
  end

  // apply sign and clamp to the signed WIDTH-bit range
  always_comb begin
    if (!s2_sign) begin
      over_c = s2_mag > POS_MAX;
      res_c  = over_c ? OUT_MAX : s2_mag[WIDTH-1:0];
    end else begin
      over_c = s2_mag > NEG_MAX;
      res_c  = over_c ? OUT_MIN : -s2_mag[WIDTH-1:0];
    end
  end

  // output registers hold their value across bubbles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout     <= '0;
      dout_sat <= 1'b0;
    end else if (v2) begin
      dout     <= res_c;
      dout_sat <= over_c | s2_spec;
    end
  end

endmodule
